// File: rtl/mc6803_pkg.sv
// Shared definitions for the MC6803 serial communications interface:
// register map, TRCSR bit positions, baud divisor table and FSM state types.
package mc6803_pkg;

   localparam logic [1:0] SCI_RMCR  = 2'd0;
   localparam logic [1:0] SCI_TRCSR = 2'd1;
   localparam logic [1:0] SCI_RDR   = 2'd2;
   localparam logic [1:0] SCI_TDR   = 2'd3;

   localparam int unsigned TRCSR_RDRF = 32'd7;
   localparam int unsigned TRCSR_ORFE = 32'd6;
   localparam int unsigned TRCSR_TDRE = 32'd5;
   localparam int unsigned TRCSR_RIE  = 32'd4;
   localparam int unsigned TRCSR_RE   = 32'd3;
   localparam int unsigned TRCSR_TIE  = 32'd2;
   localparam int unsigned TRCSR_TE   = 32'd1;
   localparam int unsigned TRCSR_WU   = 32'd0;

   typedef enum logic [2:0] {TX_IDLE, TX_PREAMBLE, TX_START, TX_DATA, TX_STOP} sci_tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} sci_rx_state_t;

   // Clocks per tick16 minus one; a bit time is 16, 128, 1024 or 4096 clk.
   function automatic logic [7:0] sci_tick_div(input logic [1:0] ss);
      case (ss)
         2'd0:    return 8'd0;
         2'd1:    return 8'd7;
         2'd2:    return 8'd63;
         default: return 8'd255;
      endcase
   endfunction

endpackage

// File: rtl/sci_baud_gen.sv
// Baud prescaler: one tick16 pulse every bit_time/16 clk, restartable on RMCR writes.
module sci_baud_gen
   import mc6803_pkg::*;
(
   input  logic       clk,
   input  logic       RST,
   input  logic [1:0] ss_i,
   input  logic       restart_i,
   output logic       tick16_o
);

   logic [7:0] cnt_q, cnt_d;
   logic       wrap_s;

   // Wrap with >= so a rate change mid-count never runs past the new divisor
   always_comb begin
      wrap_s = (cnt_q >= sci_tick_div(ss_i));
      if (restart_i || wrap_s) begin
         cnt_d = 8'd0;
      end else begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   // Prescaler count register
   always_ff @(negedge clk) begin
      if (RST) begin
         cnt_q <= 8'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick16_o = wrap_s & ~restart_i;

endmodule

// File: rtl/mc6803_sci.sv
// MC6803 on-chip SCI: register file, 8N1 transmitter and receiver.
// All state changes on the falling edge of clk (one E cycle per clk).
module mc6803_sci
   import mc6803_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       RST,
   input  logic       sel,
   input  logic       vma,
   input  logic       rw,
   input  logic [1:0] reg_addr,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   output logic       irq_sci,
   input  logic       rxd,
   output logic       txd,
   output logic       tx_en
);

   logic [3:0]             rmcr_q, rmcr_d;
   logic [4:0]             ctl_q, ctl_d;
   logic                   rdrf_q, rdrf_d, orfe_q, orfe_d, tdre_q, tdre_d;
   logic [7:0]             rdr_q, rdr_d, tdr_q, tdr_d;
   logic                   rx_arm_q, rx_arm_d, tx_arm_q, tx_arm_d, irq_q, irq_d;
   sci_tx_state_t          tx_state_q, tx_state_d;
   logic [3:0]             tx_tick_q, tx_tick_d, tx_bit_q, tx_bit_d;
   logic [7:0]             tx_shift_q, tx_shift_d;
   logic                   txd_q, txd_d, tx_en_q, tx_en_d, te_prev_q;
   sci_rx_state_t          rx_state_q, rx_state_d;
   logic [3:0]             rx_tick_q, rx_tick_d;
   logic [2:0]             rx_bit_q, rx_bit_d;
   logic [7:0]             rx_shift_q, rx_shift_d;
   logic                   rx_prev_q, rx_prev_d;
   logic [SYNC_STAGES-1:0] sync_q;

   logic rd_s, wr_s, restart_s, tick16_s, te_s, re_s, rx_s;
   logic tx_load_s, tx_bit_end_s, rx_done_s, rx_clr_s, tx_clr_s;

   assign rd_s      = sel & vma & rw;
   assign wr_s      = sel & vma & ~rw;
   assign restart_s = wr_s & (reg_addr == SCI_RMCR);
   assign te_s      = ctl_q[TRCSR_TE];
   assign re_s      = ctl_q[TRCSR_RE];
   assign rx_s      = sync_q[SYNC_STAGES-1];

   sci_baud_gen u_baud (
      .clk       (clk),
      .RST       (RST),
      .ss_i      (rmcr_q[1:0]),
      .restart_i (restart_s),
      .tick16_o  (tick16_s)
   );

   // Register read mux
   always_comb begin
      case (reg_addr)
         SCI_RMCR:  rdata = {4'd0, rmcr_q};
         SCI_TRCSR: rdata = {rdrf_q, orfe_q, tdre_q, ctl_q};
         SCI_RDR:   rdata = rdr_q;
         SCI_TDR:   rdata = tdr_q;
         default:   rdata = 8'd0;
      endcase
   end

   // Register writes, two-step flag clearing and interrupt level
   always_comb begin
      rmcr_d   = (restart_s) ? wdata[3:0] : rmcr_q;
      ctl_d    = (wr_s && reg_addr == SCI_TRCSR) ? wdata[4:0] : ctl_q;
      tdr_d    = (wr_s && reg_addr == SCI_TDR) ? wdata : tdr_q;
      rx_clr_s = rd_s & (reg_addr == SCI_RDR) & rx_arm_q;
      tx_clr_s = wr_s & (reg_addr == SCI_TDR) & tx_arm_q;
      rx_arm_d = (rd_s & (reg_addr == SCI_TRCSR) & (rdrf_q | orfe_q)) | (rx_arm_q & ~rx_clr_s);
      tx_arm_d = (rd_s & (reg_addr == SCI_TRCSR) & tdre_q) | (tx_arm_q & ~tx_clr_s);
      // A CPU write racing a shifter load still leaves TDRE clear: the new byte is pending
      tdre_d   = (tdre_q | tx_load_s) & ~tx_clr_s;
      rdrf_d   = rdrf_q & ~rx_clr_s;
      orfe_d   = orfe_q & ~rx_clr_s;
      rdr_d    = rdr_q;
      if (rx_done_s) begin
         if (!rdrf_d) begin
            rdr_d  = rx_shift_q;
            rdrf_d = 1'b1;
            orfe_d = orfe_d | ~rx_s;
         end else begin
            orfe_d = 1'b1;
         end
      end else begin
         rdr_d = rdr_q;
      end
      irq_d = (ctl_q[TRCSR_RIE] & (rdrf_q | orfe_q)) | (ctl_q[TRCSR_TIE] & tdre_q);
   end

   // Transmit FSM: IDLE reacts immediately, every other state moves on bit boundaries
   always_comb begin
      tx_state_d   = tx_state_q;
      tx_bit_d     = tx_bit_q;
      tx_shift_d   = tx_shift_q;
      tx_load_s    = 1'b0;
      tx_bit_end_s = tick16_s & (tx_tick_q == 4'd15);
      tx_tick_d    = (tick16_s) ? tx_tick_q + 4'd1 : tx_tick_q;
      case (tx_state_q)
         TX_IDLE: begin
            tx_tick_d = 4'd0;
            tx_bit_d  = 4'd0;
            if (te_s && !te_prev_q) begin
               tx_state_d = TX_PREAMBLE;
            end else if (te_s && !tdre_q) begin
               tx_state_d = TX_START;
               tx_load_s  = 1'b1;
               tx_shift_d = tdr_q;
            end else begin
               tx_state_d = TX_IDLE;
            end
         end
         TX_PREAMBLE, TX_STOP: begin
            if (tx_bit_end_s && (tx_state_q == TX_STOP || tx_bit_q == 4'd9)) begin
               tx_bit_d   = 4'd0;
               tx_load_s  = te_s & ~tdre_q;
               tx_shift_d = (tx_load_s) ? tdr_q : tx_shift_q;
               tx_state_d = (tx_load_s) ? TX_START : TX_IDLE;
            end else begin
               tx_bit_d = (tx_bit_end_s) ? tx_bit_q + 4'd1 : tx_bit_q;
            end
         end
         TX_START: begin
            tx_state_d = (tx_bit_end_s) ? TX_DATA : TX_START;
         end
         TX_DATA: begin
            if (tx_bit_end_s) begin
               tx_shift_d = {1'b0, tx_shift_q[7:1]};
               tx_bit_d   = (tx_bit_q == 4'd7) ? 4'd0 : tx_bit_q + 4'd1;
               tx_state_d = (tx_bit_q == 4'd7) ? TX_STOP : TX_DATA;
            end else begin
               tx_state_d = TX_DATA;
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase
      case (tx_state_d)
         TX_START: txd_d = 1'b0;
         TX_DATA:  txd_d = tx_shift_d[0];
         default:  txd_d = 1'b1;
      endcase
      tx_en_d = te_s | (tx_state_d != TX_IDLE);
   end

   // Receive FSM: every sample taken on tick16 from the synchronised line
   always_comb begin
      rx_state_d = rx_state_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_done_s  = 1'b0;
      rx_prev_d  = (tick16_s) ? rx_s : rx_prev_q;
      rx_tick_d  = (tick16_s) ? rx_tick_q + 4'd1 : rx_tick_q;
      case (rx_state_q)
         RX_IDLE: begin
            rx_tick_d  = 4'd0;
            rx_bit_d   = 3'd0;
            rx_state_d = (re_s && tick16_s && rx_prev_q && !rx_s) ? RX_START : RX_IDLE;
         end
         RX_START: begin
            if (tick16_s && rx_tick_q == 4'd7) begin
               rx_tick_d  = 4'd0;
               rx_state_d = (rx_s) ? RX_IDLE : RX_DATA;
            end else begin
               rx_state_d = RX_START;
            end
         end
         RX_DATA: begin
            if (tick16_s && rx_tick_q == 4'd15) begin
               rx_shift_d = {rx_s, rx_shift_q[7:1]};
               rx_bit_d   = rx_bit_q + 3'd1;
               rx_state_d = (rx_bit_q == 3'd7) ? RX_STOP : RX_DATA;
            end else begin
               rx_state_d = RX_DATA;
            end
         end
         RX_STOP: begin
            rx_done_s  = tick16_s & (rx_tick_q == 4'd15);
            rx_state_d = (rx_done_s) ? RX_IDLE : RX_STOP;
         end
         default: rx_state_d = RX_IDLE;
      endcase
      // Dropping RE abandons the frame without touching the flags
      rx_done_s  = rx_done_s & re_s;
      rx_state_d = (re_s) ? rx_state_d : RX_IDLE;
   end

   // State register for the whole SCI
   always_ff @(negedge clk) begin
      if (RST) begin
         rmcr_q     <= 4'd0;
         ctl_q      <= 5'd0;
         rdrf_q     <= 1'b0;
         orfe_q     <= 1'b0;
         tdre_q     <= 1'b1;
         rdr_q      <= 8'd0;
         tdr_q      <= 8'd0;
         rx_arm_q   <= 1'b0;
         tx_arm_q   <= 1'b0;
         irq_q      <= 1'b0;
         tx_state_q <= TX_IDLE;
         tx_tick_q  <= 4'd0;
         tx_bit_q   <= 4'd0;
         tx_shift_q <= 8'd0;
         txd_q      <= 1'b1;
         tx_en_q    <= 1'b0;
         te_prev_q  <= 1'b0;
         rx_state_q <= RX_IDLE;
         rx_tick_q  <= 4'd0;
         rx_bit_q   <= 3'd0;
         rx_shift_q <= 8'd0;
         rx_prev_q  <= 1'b1;
         sync_q     <= '1;
      end else begin
         rmcr_q     <= rmcr_d;
         ctl_q      <= ctl_d;
         rdrf_q     <= rdrf_d;
         orfe_q     <= orfe_d;
         tdre_q     <= tdre_d;
         rdr_q      <= rdr_d;
         tdr_q      <= tdr_d;
         rx_arm_q   <= rx_arm_d;
         tx_arm_q   <= tx_arm_d;
         irq_q      <= irq_d;
         tx_state_q <= tx_state_d;
         tx_tick_q  <= tx_tick_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         txd_q      <= txd_d;
         tx_en_q    <= tx_en_d;
         te_prev_q  <= te_s;
         rx_state_q <= rx_state_d;
         rx_tick_q  <= rx_tick_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         rx_prev_q  <= rx_prev_d;
         sync_q     <= {sync_q[SYNC_STAGES-2:0], rxd};
      end
   end

   assign irq_sci = irq_q;
   assign txd     = txd_q;
   assign tx_en   = tx_en_q;

endmodule

// File: tb/tb_mc6803_sci.sv
// Scoreboard bench for mc6803_sci: stimulus queues expected register reads and
// pin samples; an independent monitor compares whenever the DUT presents them.
module tb_mc6803_sci;

   logic       clk = 1'b0;
   logic       RST = 1'b1;
   logic       sel = 1'b0, vma = 1'b0, rw = 1'b1;
   logic [1:0] reg_addr = 2'd0;
   logic [7:0] wdata = 8'd0;
   logic [7:0] rdata;
   logic       irq_sci, txd, tx_en;
   logic       rxd = 1'b1;

   logic       obs_v = 1'b0;
   int         obs_sel = 0;
   int         n_cmp = 0;
   int         n_bad = 0;

   typedef struct {
      string      name;
      logic [7:0] exp;
   } exp_t;
   exp_t exp_q[$];

   localparam int P_TXD = 0, P_IRQ = 1, P_TXEN = 2;

   mc6803_sci #(.SYNC_STAGES(2)) dut (
      .clk(clk), .RST(RST), .sel(sel), .vma(vma), .rw(rw), .reg_addr(reg_addr),
      .wdata(wdata), .rdata(rdata), .irq_sci(irq_sci), .rxd(rxd), .txd(txd), .tx_en(tx_en)
   );

   always #5 clk = ~clk;

   function automatic logic pin_val(input int s);
      case (s)
         P_TXD:   return txd;
         P_IRQ:   return irq_sci;
         default: return tx_en;
      endcase
   endfunction

   task automatic check(input logic [7:0] act);
      exp_t e;
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_bad++;
         $display("FAIL unexpected_output: got %02h, nothing expected", act);
      end else begin
         e = exp_q.pop_front();
         if (act !== e.exp) begin
            n_bad++;
            $display("FAIL %s: got %02h, expected %02h", e.name, act, e.exp);
         end
      end
   endtask

   // Monitor: samples mid-cycle, well clear of the falling edge where the DUT updates
   initial begin
      forever begin
         @(posedge clk);
         #3;
         if (sel && vma && rw) begin
            check(rdata);
         end else if (obs_v) begin
            check({7'd0, pin_val(obs_sel)});
         end
      end
   end

   task automatic push(input string nm, input logic [7:0] v);
      exp_t e;
      e.name = nm;
      e.exp  = v;
      exp_q.push_back(e);
   endtask

   task automatic bus(input logic rw_i, input logic [1:0] a, input logic [7:0] d);
      @(posedge clk); #1;
      sel = 1'b1; vma = 1'b1; rw = rw_i; reg_addr = a; wdata = d;
      @(negedge clk); #1;
      sel = 1'b0; vma = 1'b0; rw = 1'b1;
   endtask

   task automatic rd(input logic [1:0] a, input logic [7:0] v, input string nm);
      push(nm, v);
      bus(1'b1, a, 8'd0);
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      bus(1'b0, a, d);
   endtask

   task automatic skip(input int n);
      repeat (n) @(posedge clk);
   endtask

   // Queue a pin expectation, sampled at the next rising edge
   task automatic pin(input int s, input logic v, input string nm);
      push(nm, {7'd0, v});
      obs_sel = s;
      @(posedge clk); #1 obs_v = 1'b1;
      #3 obs_v = 1'b0;
   endtask

   task automatic wait_pin(input int s, input logic v, input int max, input string nm);
      bit hit = 1'b0;
      for (int i = 0; i < max && !hit; i++) begin
         @(posedge clk); #3;
         hit = (pin_val(s) === v);
      end
      if (!hit) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: pin never reached %0b within %0d clk", nm, v, max);
      end
   endtask

   task automatic send(input logic [7:0] b, input logic stopb, input int cpb);
      rxd = 1'b0;
      skip(cpb);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         skip(cpb);
      end
      rxd = stopb;
      skip(cpb);
      rxd = 1'b1;
   endtask

   initial begin
      logic [7:0] txb;
      // 1. reset state
      skip(3);
      #1 RST = 1'b0;
      rd(2'd0, 8'h00, "rst_rmcr");
      rd(2'd1, 8'h20, "rst_trcsr");
      rd(2'd2, 8'h00, "rst_rdr");
      rd(2'd3, 8'h00, "rst_tdr");
      pin(P_TXD, 1'b1, "rst_txd");
      pin(P_IRQ, 1'b0, "rst_irq");
      pin(P_TXEN, 1'b0, "rst_tx_en");

      // 2. transmit 55 at 16 clk/bit after a 10-bit preamble
      wr(2'd0, 8'h00);
      rd(2'd1, 8'h20, "tx_arm_trcsr");
      wr(2'd3, 8'h55);
      rd(2'd1, 8'h00, "tdre_cleared");
      wr(2'd1, 8'h02);
      wait_pin(P_TXEN, 1'b1, 20, "tx_en_rise");
      skip(158);
      pin(P_TXD, 1'b1, "preamble_last");
      pin(P_TXD, 1'b0, "start_bit");
      txb = 8'h55;
      for (int i = 0; i < 8; i++) begin
         skip(15);
         pin(P_TXD, txb[i], "tx_data_bit");
      end
      skip(15);
      pin(P_TXD, 1'b1, "stop_bit");
      rd(2'd1, 8'h22, "tdre_after_load");
      wr(2'd1, 8'h00);

      // 3. receive A3 at 128 clk/bit
      wr(2'd0, 8'h01);
      wr(2'd1, 8'h08);
      send(8'hA3, 1'b1, 128);
      wr(2'd1, 8'h00);
      rd(2'd1, 8'hA0, "rx_rdrf");
      rd(2'd2, 8'hA3, "rx_data");
      rd(2'd1, 8'h20, "rx_cleared");

      // 4. overrun keeps the first byte; a zero stop bit flags ORFE
      wr(2'd1, 8'h08);
      send(8'h11, 1'b1, 128);
      send(8'h22, 1'b1, 128);
      wr(2'd1, 8'h00);
      rd(2'd1, 8'hE0, "overrun_flags");
      rd(2'd2, 8'h11, "overrun_rdr");
      rd(2'd1, 8'h20, "overrun_cleared");
      wr(2'd1, 8'h08);
      send(8'h5A, 1'b0, 128);
      skip(20);
      wr(2'd1, 8'h00);
      rd(2'd1, 8'hE0, "framing_flags");
      rd(2'd2, 8'h5A, "framing_rdr");
      rd(2'd1, 8'h20, "framing_cleared");

      // 5. a 4-clk glitch at 16 clk/bit is rejected, the next frame still lands
      wr(2'd0, 8'h00);
      wr(2'd1, 8'h08);
      rxd = 1'b0;
      skip(4);
      rxd = 1'b1;
      skip(40);
      rd(2'd1, 8'h28, "glitch_no_rdrf");
      send(8'h3C, 1'b1, 16);
      skip(4);
      rd(2'd1, 8'hA8, "post_glitch_rdrf");
      rd(2'd2, 8'h3C, "post_glitch_rdr");
      rd(2'd1, 8'h28, "post_glitch_cleared");

      // 6. interrupts, then reset in the middle of a frame
      wr(2'd1, 8'h04);
      pin(P_IRQ, 1'b0, "tie_irq_latency");
      pin(P_IRQ, 1'b1, "tie_irq_set");
      rd(2'd1, 8'h24, "tie_trcsr");
      wr(2'd3, 8'h77);
      pin(P_IRQ, 1'b1, "tie_irq_hold");
      pin(P_IRQ, 1'b0, "tie_irq_clear");
      wr(2'd1, 8'h18);
      pin(P_IRQ, 1'b0, "rie_irq_idle");
      send(8'h81, 1'b1, 16);
      skip(2);
      pin(P_IRQ, 1'b1, "rie_irq_set");
      rd(2'd1, 8'h98, "rie_trcsr");
      rd(2'd2, 8'h81, "rie_rdr");
      skip(1);
      pin(P_IRQ, 1'b0, "rie_irq_clear");
      wr(2'd1, 8'h02);
      wait_pin(P_TXD, 1'b0, 400, "mid_tx_start");
      RST = 1'b1;
      pin(P_TXD, 1'b1, "rst_mid_tx_txd");
      pin(P_TXEN, 1'b0, "rst_mid_tx_en");
      #1 RST = 1'b0;
      rd(2'd0, 8'h00, "rst2_rmcr");
      rd(2'd1, 8'h20, "rst2_trcsr");
      rd(2'd2, 8'h00, "rst2_rdr");
      rd(2'd3, 8'h00, "rst2_tdr");
      pin(P_IRQ, 1'b0, "rst2_irq");

      skip(5);
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL leftover_expectations: %0d still queued, expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
